fft_stage_ctrl: RTL and testbench

Sequencer for the 128-point in-place radix-2 FFT core. It sits directly upstream of the butterfly address generator and drives its layer index, one-hot layer vector and butterfly count. Each layer issues one butterfly read per cycle, then drains the butterfly pipeline so the next layer reads written-back results. It also produces delayed write-back strobes and indices for the RAM write port.

---
 rtl/fft_stage_ctrl_if.sv | 36 +++
 rtl/fft_stage_ctrl.sv | 165 ++++++++++++++++
 tb/tb_fft_stage_ctrl.sv | 283 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fft_stage_ctrl_if.sv
// rtl/fft_stage_ctrl_if.sv - control/status bundle between the FFT stage sequencer and its consumers
// Ports (slave = sequencer side):
//   start       in   request one full transform
//   busy, done  out  transform status
//   lay_cnt, r_lay_cnt, bf_cnt, rd_en              out  read-side sequencing
//   wr_en, wr_lay_cnt, wr_bf_cnt, layer_done       out  write-back side sequencing
interface fft_stage_ctrl_if #(
    parameter int LOG2N = 7
);
    localparam int LW = $clog2(LOG2N);
    localparam int BW = LOG2N - 1;

    logic          start;
    logic          busy;
    logic          done;
    logic [LW-1:0] lay_cnt;
    logic [LOG2N-1:0] r_lay_cnt;
    logic [BW-1:0] bf_cnt;
    logic          rd_en;
    logic          wr_en;
    logic [LW-1:0] wr_lay_cnt;
    logic [BW-1:0] wr_bf_cnt;
    logic          layer_done;

    modport slave (
        input  start,
        output busy, done, lay_cnt, r_lay_cnt, bf_cnt, rd_en,
               wr_en, wr_lay_cnt, wr_bf_cnt, layer_done
    );

    modport master (
        output start,
        input  busy, done, lay_cnt, r_lay_cnt, bf_cnt, rd_en,
               wr_en, wr_lay_cnt, wr_bf_cnt, layer_done
    );
endinterface

// File: rtl/fft_stage_ctrl.sv
// rtl/fft_stage_ctrl.sv - layer/butterfly sequencer for an in-place radix-2 FFT core
// Ports:
//   clk    in  system clock, rising edge
//   rst_n  in  asynchronous active-low reset
//   bus    fft_stage_ctrl_if.slave: start in; busy, done, lay_cnt, r_lay_cnt,
//          bf_cnt, rd_en, wr_en, wr_lay_cnt, wr_bf_cnt, layer_done out
// Every output is a flop; the write-back side is a BF_LAT-deep delay of the read side.
module fft_stage_ctrl #(
    parameter int LOG2N  = 7,
    parameter int BF_LAT = 4
) (
    input  logic clk,
    input  logic rst_n,
    fft_stage_ctrl_if.slave bus
);
    localparam int LW = $clog2(LOG2N);
    localparam int BW = LOG2N - 1;
    localparam logic [BW-1:0] BF_LAST  = '1;
    localparam logic [LW-1:0] LAY_LAST = LW'(LOG2N - 1);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

    state_t r_state, w_state_nxt;

    logic             r_busy, r_done, r_rd_en, r_layer_done;
    logic [LW-1:0]    r_lay;
    logic [LOG2N-1:0] r_lay_oh;
    logic [BW-1:0]    r_bf;

    logic             w_busy_nxt, w_done_nxt, w_rd_en_nxt, w_layer_done_nxt;
    logic [LW-1:0]    w_lay_nxt;
    logic [LOG2N-1:0] w_lay_oh_nxt;
    logic [BW-1:0]    w_bf_nxt;

    // Write-back delay line, stage BF_LAT drives the wr_* outputs.
    logic          r_dly_en  [1:BF_LAT];
    logic [LW-1:0] r_dly_lay [1:BF_LAT];
    logic [BW-1:0] r_dly_bf  [1:BF_LAT];

    // What the write side will show next cycle; used so layer_done can be a
    // flop yet still line up with the last write-back of the layer.
    logic          w_pre_en;
    logic [BW-1:0] w_pre_bf;

    generate
        if (BF_LAT == 1) begin : g_pre_head
            assign w_pre_en = r_rd_en;
            assign w_pre_bf = r_bf;
        end else begin : g_pre_dly
            assign w_pre_en = r_dly_en[BF_LAT-1];
            assign w_pre_bf = r_dly_bf[BF_LAT-1];
        end
    endgenerate

    // State and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_rd_en      <= 1'b0;
            r_layer_done <= 1'b0;
            r_lay        <= '0;
            r_lay_oh     <= LOG2N'(1);
            r_bf         <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_busy       <= w_busy_nxt;
            r_done       <= w_done_nxt;
            r_rd_en      <= w_rd_en_nxt;
            r_layer_done <= w_layer_done_nxt;
            r_lay        <= w_lay_nxt;
            r_lay_oh     <= w_lay_oh_nxt;
            r_bf         <= w_bf_nxt;
        end
    end

    // Next state. The layer ends when its last write-back is on the bus
    // (r_layer_done), so the next layer never reads stale RAM contents.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (bus.start) w_state_nxt = S_RUN;
            S_RUN:   if (r_bf == BF_LAST) w_state_nxt = S_DRAIN;
            S_DRAIN: if (r_layer_done) w_state_nxt = (r_lay == LAY_LAST) ? S_DONE : S_RUN;
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Output values for the state being entered
    always_comb begin
        w_busy_nxt       = r_busy;
        w_done_nxt       = 1'b0;
        w_rd_en_nxt      = 1'b0;
        w_lay_nxt        = r_lay;
        w_lay_oh_nxt     = r_lay_oh;
        w_bf_nxt         = r_bf;
        w_layer_done_nxt = w_pre_en && (w_pre_bf == BF_LAST);
        case (w_state_nxt)
            S_RUN: begin
                w_busy_nxt  = 1'b1;
                w_rd_en_nxt = 1'b1;
                if (r_state == S_RUN) begin
                    w_bf_nxt = r_bf + BW'(1);
                end else if (r_state == S_DRAIN) begin
                    w_lay_nxt    = r_lay + LW'(1);
                    w_lay_oh_nxt = {r_lay_oh[LOG2N-2:0], 1'b0};
                    w_bf_nxt     = '0;
                end else begin
                    w_lay_nxt    = '0;
                    w_lay_oh_nxt = LOG2N'(1);
                    w_bf_nxt     = '0;
                end
            end
            S_DRAIN: begin
                w_busy_nxt = 1'b1;
                w_bf_nxt   = '0;
            end
            S_DONE: begin
                w_busy_nxt   = 1'b0;
                w_done_nxt   = 1'b1;
                w_lay_nxt    = '0;
                w_lay_oh_nxt = LOG2N'(1);
                w_bf_nxt     = '0;
            end
            default: begin
                w_busy_nxt   = 1'b0;
                w_lay_nxt    = '0;
                w_lay_oh_nxt = LOG2N'(1);
                w_bf_nxt     = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 1; i <= BF_LAT; i++) begin
                r_dly_en[i]  <= 1'b0;
                r_dly_lay[i] <= '0;
                r_dly_bf[i]  <= '0;
            end
        end else begin
            r_dly_en[1]  <= r_rd_en;
            r_dly_lay[1] <= r_lay;
            r_dly_bf[1]  <= r_bf;
            for (int i = 2; i <= BF_LAT; i++) begin
                r_dly_en[i]  <= r_dly_en[i-1];
                r_dly_lay[i] <= r_dly_lay[i-1];
                r_dly_bf[i]  <= r_dly_bf[i-1];
            end
        end
    end

    assign bus.busy       = r_busy;
    assign bus.done       = r_done;
    assign bus.lay_cnt    = r_lay;
    assign bus.r_lay_cnt  = r_lay_oh;
    assign bus.bf_cnt     = r_bf;
    assign bus.rd_en      = r_rd_en;
    assign bus.layer_done = r_layer_done;
    assign bus.wr_en      = r_dly_en[BF_LAT];
    assign bus.wr_lay_cnt = r_dly_lay[BF_LAT];
    assign bus.wr_bf_cnt  = r_dly_bf[BF_LAT];
endmodule

// File: tb/tb_fft_stage_ctrl.sv
// tb/tb_fft_stage_ctrl.sv - self-checking bench for fft_stage_ctrl (BF_LAT=4 and BF_LAT=1 instances)
module tb_fft_stage_ctrl;
    localparam int NCYC = 490;

    typedef struct packed {
        logic       rd;
        logic [2:0] lay;
        logic [6:0] oh;
        logic [5:0] bf;
        logic       wr;
        logic [2:0] wl;
        logic [5:0] wb;
        logic       ld;
        logic       dn;
        logic       busy;
    } obs_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    fft_stage_ctrl_if if4 ();
    fft_stage_ctrl_if if1 ();

    fft_stage_ctrl #(.LOG2N(7), .BF_LAT(4)) u_dut4 (.clk(clk), .rst_n(rst_n), .bus(if4.slave));
    fft_stage_ctrl #(.LOG2N(7), .BF_LAT(1)) u_dut1 (.clk(clk), .rst_n(rst_n), .bus(if1.slave));

    obs_t o4, o1;
    assign o4 = {if4.rd_en, if4.lay_cnt, if4.r_lay_cnt, if4.bf_cnt, if4.wr_en,
                 if4.wr_lay_cnt, if4.wr_bf_cnt, if4.layer_done, if4.done, if4.busy};
    assign o1 = {if1.rd_en, if1.lay_cnt, if1.r_lay_cnt, if1.bf_cnt, if1.wr_en,
                 if1.wr_lay_cnt, if1.wr_bf_cnt, if1.layer_done, if1.done, if1.busy};

    obs_t q4[$];
    obs_t q1[$];

    // Reference timeline: t is cycles after the cycle in which start was sampled.
    function automatic obs_t model(int lat, int t);
        obs_t e;
        int per, tt, k, p, tw;
        e = '0;
        e.oh = 7'h01;
        per = 64 + lat;
        tt = 7 * per;
        if (t >= 1 && t <= tt) begin
            k = (t - 1) / per;
            p = (t - 1) % per;
            e.busy = 1'b1;
            e.lay  = 3'(k);
            e.oh   = 7'(1 << k);
            if (p < 64) begin
                e.rd = 1'b1;
                e.bf = 6'(p);
            end
            tw = t - lat;
            if (tw >= 1) begin
                p = (tw - 1) % per;
                if (p < 64) begin
                    e.wr = 1'b1;
                    e.wl = 3'((tw - 1) / per);
                    e.wb = 6'(p);
                    e.ld = (p == 63);
                end
            end
        end else if (t == tt + 1) begin
            e.dn = 1'b1;
        end
        return e;
    endfunction

    // Write-side fields are don't-care while wr_en is low.
    function automatic obs_t mask(obs_t o, obs_t e);
        obs_t m;
        m = o;
        if (!e.wr) begin
            m.wl = '0;
            m.wb = '0;
        end
        return m;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        obs_t e, m;
        rst_n = 1'b0;
        if4.start = 1'b0;
        if1.start = 1'b0;
        step();
        step();
        #3;
        e = model(4, 0);
        checks++;
        if (o4 !== e) begin
            errors++;
            $display("FAIL reset_hold dut4 got=%h exp=%h", o4, e);
        end
        step();
        rst_n = 1'b1;
        for (int t = 0; t < 20; t++) begin
            q4.push_back(model(4, 0));
            q1.push_back(model(1, 0));
        end
        for (int t = 0; t < 20; t++) begin
            #3;
            e = q4.pop_front();
            m = o4;
            checks++;
            if (m !== e) begin
                errors++;
                $display("FAIL idle_dut4 cyc=%0d got=%h exp=%h", t, m, e);
            end
            e = q1.pop_front();
            m = o1;
            checks++;
            if (m !== e) begin
                errors++;
                $display("FAIL idle_dut1 cyc=%0d got=%h exp=%h", t, m, e);
            end
            step();
        end
    endtask

    task automatic test_transform(input bit noise);
        obs_t e, m;
        int n_rd4, n_wr4, n_ld4, n_dn4, n_rd1, n_wr1, n_ld1, n_dn1;
        logic [5:0] prev_bf1;
        logic [2:0] prev_lay1;
        logic       prev_rd1;
        n_rd4 = 0; n_wr4 = 0; n_ld4 = 0; n_dn4 = 0;
        n_rd1 = 0; n_wr1 = 0; n_ld1 = 0; n_dn1 = 0;
        prev_bf1 = '0; prev_lay1 = '0; prev_rd1 = 1'b0;
        for (int t = 1; t <= NCYC; t++) begin
            q4.push_back(model(4, t));
            q1.push_back(model(1, t));
        end
        if4.start = 1'b1;
        if1.start = 1'b1;
        step();
        if1.start = 1'b0;
        for (int t = 1; t <= NCYC; t++) begin
            if4.start = noise && (t == 10 || t == 200 || t == 477);
            #3;
            e = q4.pop_front();
            m = mask(o4, e);
            checks++;
            if (m !== e) begin
                errors++;
                $display("FAIL seq_dut4 noise=%0d cyc=%0d got=%h exp=%h", noise, t, m, e);
            end
            e = q1.pop_front();
            m = mask(o1, e);
            checks++;
            if (m !== e) begin
                errors++;
                $display("FAIL seq_dut1 noise=%0d cyc=%0d got=%h exp=%h", noise, t, m, e);
            end
            if (if1.wr_en) begin
                checks++;
                if (!prev_rd1 || if1.wr_bf_cnt !== prev_bf1 || if1.wr_lay_cnt !== prev_lay1) begin
                    errors++;
                    $display("FAIL wr_follow_dut1 cyc=%0d got=%0d/%0d exp=%0d/%0d", t,
                             if1.wr_lay_cnt, if1.wr_bf_cnt, prev_lay1, prev_bf1);
                end
            end
            prev_bf1  = if1.bf_cnt;
            prev_lay1 = if1.lay_cnt;
            prev_rd1  = if1.rd_en;
            n_rd4 += int'(if4.rd_en); n_wr4 += int'(if4.wr_en);
            n_ld4 += int'(if4.layer_done); n_dn4 += int'(if4.done);
            n_rd1 += int'(if1.rd_en); n_wr1 += int'(if1.wr_en);
            n_ld1 += int'(if1.layer_done); n_dn1 += int'(if1.done);
            step();
        end
        if4.start = 1'b0;
        checks++;
        if (n_rd4 != 448 || n_wr4 != 448 || n_ld4 != 7 || n_dn4 != 1) begin
            errors++;
            $display("FAIL totals_dut4 got rd=%0d wr=%0d ld=%0d dn=%0d exp 448 448 7 1",
                     n_rd4, n_wr4, n_ld4, n_dn4);
        end
        checks++;
        if (n_rd1 != 448 || n_wr1 != 448 || n_ld1 != 7 || n_dn1 != 1) begin
            errors++;
            $display("FAIL totals_dut1 got rd=%0d wr=%0d ld=%0d dn=%0d exp 448 448 7 1",
                     n_rd1, n_wr1, n_ld1, n_dn1);
        end
    endtask

    task automatic test_midreset();
        obs_t e, m;
        for (int t = 1; t <= 149; t++) q4.push_back(model(4, t));
        if4.start = 1'b1;
        step();
        if4.start = 1'b0;
        for (int t = 1; t <= 149; t++) begin
            #3;
            e = q4.pop_front();
            m = mask(o4, e);
            checks++;
            if (m !== e) begin
                errors++;
                $display("FAIL pre_reset_dut4 cyc=%0d got=%h exp=%h", t, m, e);
            end
            step();
        end
        rst_n = 1'b0;
        #1;
        e = model(4, 0);
        checks++;
        if (o4 !== e) begin
            errors++;
            $display("FAIL async_reset_dut4 got=%h exp=%h", o4, e);
        end
        step();
        step();
        rst_n = 1'b1;
        for (int t = 0; t < 10; t++) q4.push_back(model(4, 0));
        for (int t = 0; t < 10; t++) begin
            #3;
            e = q4.pop_front();
            checks++;
            if (o4 !== e) begin
                errors++;
                $display("FAIL post_reset_idle_dut4 cyc=%0d got=%h exp=%h", t, o4, e);
            end
            step();
        end
        for (int t = 1; t <= NCYC; t++) q4.push_back(model(4, t));
        if4.start = 1'b1;
        step();
        if4.start = 1'b0;
        for (int t = 1; t <= NCYC; t++) begin
            #3;
            e = q4.pop_front();
            m = mask(o4, e);
            checks++;
            if (m !== e) begin
                errors++;
                $display("FAIL restart_dut4 cyc=%0d got=%h exp=%h", t, m, e);
            end
            step();
        end
    endtask

    task automatic test_back_to_back();
        obs_t e, m;
        for (int t = 1; t <= 500; t++)
            q4.push_back((t <= 478) ? model(4, t) : model(4, t - 478));
        if4.start = 1'b1;
        step();
        for (int t = 1; t <= 500; t++) begin
            #3;
            e = q4.pop_front();
            m = mask(o4, e);
            checks++;
            if (m !== e) begin
                errors++;
                $display("FAIL held_start_dut4 cyc=%0d got=%h exp=%h", t, m, e);
            end
            step();
        end
        if4.start = 1'b0;
    endtask

    initial begin
        if4.start = 1'b0;
        if1.start = 1'b0;
        test_reset();
        test_transform(1'b0);
        test_transform(1'b1);
        test_midreset();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
